// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported memory between instruction fetch and the
// execute-stage load/store path. One access is in flight at a time: a
// request is granted combinationally while IDLE, the arbiter then waits
// out the fixed read latency in BUSY and hands the returned word to the
// requester that owns the access. While an access is in flight, or while
// any request is pending, the core is stalled.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width
//   MEM_LAT     memory read latency in cycles (1..4)
//   STARVE_MAX  contested data grants in a row before fetch is forced (1..7)
//
// Ports
//   clk, reset                       clock, async active-low reset
//   if_req/if_addr                   fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata        fetch accept, return pulse, instruction
//   d_req/d_we/d_addr/d_wdata        data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata           data accept, completion pulse, load data
//   mem_en/mem_we/mem_addr/mem_wdata memory request side
//   mem_rdata                        memory read data, MEM_LAT after mem_en
//   stall                            freeze PC and pipeline
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT);
  localparam logic [2:0] STREAK_CAP = 3'(STARVE_MAX);

  state_t            state;
  owner_t            owner;
  logic              op_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        cnt;
  logic [2:0]        streak;

  logic idle;
  logic starved;
  logic pick_f;
  logic pick_d;
  logic last_cyc;

  // Request selection (IDLE only)
  assign idle    = (state == IDLE);
  assign starved = (streak == STREAK_CAP);
  // Data normally wins; once data has won STARVE_MAX contested grants in a
  // row, fetch gets the next contested slot.
  assign pick_f  = if_req & (~d_req | starved);
  assign pick_d  = d_req & ~pick_f;

  assign if_gnt  = idle & pick_f;
  assign d_gnt   = idle & pick_d;
  assign mem_en  = if_gnt | d_gnt;
  assign mem_we  = d_gnt & d_we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (!idle) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end else if (pick_f) begin
      mem_addr  = if_addr;
    end else if (pick_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Return path: only registered state decides the completion pulse
  assign last_cyc  = (state == BUSY) && (cnt == 3'd1);
  assign if_rvalid = last_cyc && (owner == OWN_FETCH);
  assign d_rvalid  = last_cyc && (owner == OWN_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  // A store completes with an acknowledge only; the read port value is junk.
  assign d_rdata   = (d_rvalid && !op_we) ? mem_rdata : '0;

  assign stall = ~idle | if_req | d_req;

  // Control and latched access state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= OWN_FETCH;
      op_we   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= 3'd0;
      streak  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_en) begin
            state   <= BUSY;
            cnt     <= LAT_LOAD;
            owner   <= if_gnt ? OWN_FETCH : OWN_DATA;
            op_we   <= mem_we;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            if (if_gnt || !if_req)
              streak <= 3'd0;
            else if (!starved)
              streak <= streak + 3'd1;
          end
        end
        BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a memory model and a return-path
// scoreboard: each grant pushes the expected owner/word/cycle, and every
// rvalid pulse pops and compares one entry.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
  );

  // Memory model: samples on the edge ending the issue cycle, data appears
  // LAT cycles later. Word 0x40 holds 0xDEADBEEF, others 0xC0DE0000|index.
  logic          mem_init;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_pipe [0:LAT-1];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    rd_pipe[0] <= mem_en ? mem[mem_addr[9:2]] : 32'hA5A5A5A5;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [159:0] outs();
    return {25'b0, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
            mem_en, mem_we, mem_addr, mem_wdata, stall};
  endfunction

  typedef struct packed {
    logic        is_f;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (if_rvalid || d_rvalid) begin
        chk("rv_both", {159'b0, if_rvalid & d_rvalid}, 160'd0);
        if (sb.size() == 0) begin
          chk("rv_spurious", {158'b0, if_rvalid, d_rvalid}, 160'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rv_owner", {159'b0, if_rvalid}, {159'b0, mon_e.is_f});
          chk("rv_data", {128'b0, (mon_e.is_f ? if_rdata : d_rdata)}, {128'b0, mon_e.data});
          chk("rv_cycle", 160'(cyc), 160'(mon_e.due));
        end
      end else begin
        chk("rdata_idle_zero", {96'b0, if_rdata, d_rdata}, 160'd0);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Waits (bounded) for a grant in the contention phase and records it.
  task automatic wait_gnt(output logic got_f, output logic ok);
    ok    = 1'b0;
    got_f = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      mid();
      if (if_gnt || d_gnt) begin
        ok    = 1'b1;
        got_f = if_gnt;
        chk("one_gnt", {159'b0, if_gnt & d_gnt}, 160'd0);
        sb.push_back('{is_f: if_gnt, data: (if_gnt ? 32'hC0DE0020 : 32'hC0DE0021), due: cyc + LAT});
      end
      next_cyc();
    end
    if (!ok) begin
      n_total++;
      $error("FAIL gnt_timeout: observed no grant expected grant within 8 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  logic got_f, ok;

  initial begin
    mem_init = 1'b1;
    reset    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;

    // reset and idle
    repeat (3) begin
      mid();
      chk("reset_outs", outs(), 160'd0);
      next_cyc();
    end
    mem_init = 1'b0;
    reset    = 1'b1;
    repeat (3) begin
      mid();
      chk("idle_outs", outs(), 160'd0);
      next_cyc();
    end

    // single fetch
    if_req  = 1'b1;
    if_addr = 32'h40;
    mid();
    chk("f_gnt", {158'b0, if_gnt, d_gnt}, {158'b0, 2'b10});
    chk("f_mem", {126'b0, mem_en, mem_we, mem_addr}, {126'b0, 2'b10, 32'h40});
    sb.push_back('{is_f: 1'b1, data: 32'hDEADBEEF, due: cyc + LAT});
    next_cyc();
    if_req = 1'b0;
    mid();
    chk("f_busy", {156'b0, mem_en, if_gnt, if_rvalid, stall}, {156'b0, 4'b0001});
    next_cyc();
    mid();
    chk("f_rvalid", {127'b0, if_rvalid, if_rdata}, {127'b0, 1'b1, 32'hDEADBEEF});
    next_cyc();
    mid();
    chk("f_back_idle", outs(), 160'd0);
    next_cyc();

    // store then load to the same word
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'h12345678;
    mid();
    chk("st_issue", {94'b0, d_gnt, if_gnt, mem_en, mem_we, mem_addr, mem_wdata},
        {94'b0, 4'b1011, 32'h100, 32'h12345678});
    sb.push_back('{is_f: 1'b0, data: 32'h0, due: cyc + LAT});
    next_cyc();
    d_we = 1'b0;
    mid();
    chk("st_busy1", {95'b0, d_gnt, mem_en, mem_we, mem_addr, mem_wdata},
        {95'b0, 3'b000, 32'h100, 32'h12345678});
    next_cyc();
    mid();
    chk("st_ack", {126'b0, d_gnt, d_rvalid, d_rdata}, {126'b0, 2'b01, 32'h0});
    next_cyc();
    mid();
    chk("ld_issue", {157'b0, d_gnt, mem_en, mem_we}, {157'b0, 3'b110});
    sb.push_back('{is_f: 1'b0, data: 32'h12345678, due: cyc + LAT});
    next_cyc();
    d_req = 1'b0;
    repeat (3) next_cyc();

    // contention and anti-starvation
    if_addr = 32'h80;
    d_addr  = 32'h84;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    for (int g = 0; g < 8; g++) begin
      wait_gnt(got_f, ok);
      if (ok) chk($sformatf("order_%0d", g), {159'b0, got_f}, {159'b0, (g == 3 || g == 7)});
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (4) next_cyc();

    // reset in the middle of a load
    d_req  = 1'b1;
    d_addr = 32'h84;
    mid();
    chk("rst_ld_gnt", {159'b0, d_gnt}, {159'b0, 1'b1});
    next_cyc();
    d_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_abort", {127'b0, stall, mem_addr}, 160'd0);
    mid();
    reset = 1'b1;
    next_cyc();
    mid();
    chk("rst_no_rvalid", {158'b0, d_rvalid, stall}, 160'd0);
    next_cyc();
    d_req  = 1'b1;
    d_addr = 32'h100;
    mid();
    chk("post_rst_gnt", {159'b0, d_gnt}, {159'b0, 1'b1});
    sb.push_back('{is_f: 1'b0, data: 32'h12345678, due: cyc + LAT});
    next_cyc();
    d_req = 1'b0;
    repeat (3) next_cyc();

    // data request held while a fetch is in flight
    if_req  = 1'b1;
    if_addr = 32'h40;
    mid();
    chk("hold_f_gnt", {158'b0, if_gnt, stall}, {158'b0, 2'b11});
    sb.push_back('{is_f: 1'b1, data: 32'hDEADBEEF, due: cyc + LAT});
    next_cyc();
    if_req = 1'b0;
    d_req  = 1'b1;
    d_addr = 32'h100;
    mid();
    chk("hold_t1", {158'b0, d_gnt, stall}, {158'b0, 2'b01});
    next_cyc();
    mid();
    chk("hold_t2", {158'b0, d_gnt, stall}, {158'b0, 2'b01});
    next_cyc();
    mid();
    chk("hold_t3", {158'b0, d_gnt, stall}, {158'b0, 2'b11});
    sb.push_back('{is_f: 1'b0, data: 32'h12345678, due: cyc + LAT});
    next_cyc();
    d_req = 1'b0;
    mid();
    chk("hold_t4_stall", {159'b0, stall}, {159'b0, 1'b1});
    next_cyc();
    mid();
    chk("hold_t5_stall", {159'b0, stall}, {159'b0, 1'b1});
    next_cyc();
    mid();
    chk("hold_t6_stall", {159'b0, stall}, 160'd0);
    next_cyc();

    repeat (3) next_cyc();
    chk("sb_empty", 160'(sb.size()), 160'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported instruction/data memory between the instruction-fetch stage and the execute stage's load/store path. It accepts one request at a time from either side and issues it to memory. It tracks the fixed read latency and routes the returned word back to the originator. It drives a core-wide stall while an access is in flight. It sits between the IF/EX stages and the memory wrapper in the SCC top level.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles, legal 1..4
- STARVE_MAX, 3, consecutive contested data grants before fetch is forced, legal 1..7
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle completion pulse (load data or store ack)
- d_rdata  out  DATA_W  load data; 0 on store ack
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- stall  out  1  freeze PC and pipeline

## Operation
- FSM states: IDLE and BUSY. A single transaction is outstanding at most.
- IDLE with no request: all strobes are 0.
- IDLE with any request: grant one requester combinationally in the same cycle.
  - Assert mem_en and drive mem_we/mem_addr/mem_wdata from the winner.
  - Latch the owner (FETCH/DATA), the op, and the address.
  - Load the latency counter with MEM_LAT and go to BUSY.
- Priority: data wins over fetch, except when both request and streak == STARVE_MAX; then fetch wins.
- streak counter (3 bit):
  - cleared on any fetch grant;
  - cleared on a data grant when if_req = 0;
  - incremented, saturating at STARVE_MAX, on a data grant when if_req = 1.
- BUSY: mem_en = 0, mem_we = 0. mem_addr and mem_wdata hold the latched values. The counter decrements each cycle.
- Counter reaching 1 (the last BUSY cycle): pulse the owner's rvalid.
  - rdata = mem_rdata for loads and fetches; 0 for stores.
  - Return to IDLE next edge.
- No grant is issued while BUSY. Requests arriving during BUSY wait and must be held.
- A requester dropping req before its gnt is legal; the request is simply withdrawn.
- Unselected rvalid/gnt are 0. if_rdata/d_rdata are 0 whenever their rvalid is 0.
- stall = (state == BUSY) | if_req | d_req.

## Timing
- Reset (reset = 0, asynchronous):
  - state = IDLE, counter = 0, streak = 0, owner = FETCH.
  - Latched address/data = 0.
  - All outputs 0 except stall, which follows its combinational equation on the inputs.
- Reset asserted mid-BUSY aborts the access; no rvalid is ever produced for it.
- Issue at cycle t (gnt = mem_en = 1); rvalid at cycle t + MEM_LAT; next grant earliest at t + MEM_LAT + 1.
- Throughput is one access per MEM_LAT + 1 cycles.
- gnt and mem_en are combinational from requests in IDLE. rvalid is derived from registered state only.
- Simultaneous if_req and d_req in IDLE: exactly one gnt; the other remains pending.
- The memory wrapper must sample mem_en/mem_addr on the rising edge ending cycle t.

## Test plan
- Reset and idle:
  - Stimulus: reset = 0 for 3 cycles, then 1, no requests.
  - Required: all outputs 0, stall = 0, mem_en never 1.
- Single fetch, MEM_LAT = 2:
  - Stimulus: if_req with if_addr = 0x40 at t0; memory returns 0xDEADBEEF.
  - Required: if_gnt = 1 and mem_addr = 0x40 at t0; if_rvalid = 1 with if_rdata = 0xDEADBEEF at t2; IDLE at t3.
- Store then load:
  - Stimulus: store d_addr = 0x100, d_wdata = 0x12345678; then load 0x100.
  - Required: mem_we = 1 only at the store's issue cycle; d_rvalid with d_rdata = 0 at issue + 2; load returns 0x12345678 at its issue + 2; load grant no earlier than store issue + 3.
- Contention and anti-starvation:
  - Stimulus: if_req and d_req held continuously, STARVE_MAX = 3.
  - Required: grant order D, D, D, F, D, D, D, F; streak resets after each F.
- Reset mid-operation:
  - Stimulus: grant a load at t0; pulse reset = 0 at t1.
  - Required: state IDLE immediately; no d_rvalid at t2; a new request after reset completes normally.
- Held request during BUSY:
  - Stimulus: d_req rises at t1 while a fetch is BUSY.
  - Required: d_gnt = 0 through t2; d_gnt = 1 at t3; stall = 1 continuously from t0 until completion.
